e_md_unit: RTL and testbench
============================

# e_md_unit

Execute-stage multiply/divide unit for the pipelined MIPS core. It consumes the rs/rt operands and the MD operation that the D→E pipeline register presents to the E stage. It runs mult/div as multi-cycle operations against private HI/LO registers and serves mfhi/mflo reads. It also produces the D-stage stall request that holds MD instructions in decode while the unit is occupied.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  in  1  single system clock, all state on rising edge
- reset  in  1  synchronous, active-high; sampled only on rising edge of clk
- E_MD_op  in  4  E-stage MD opcode: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, others = none
- E_MD_start  in  1  E stage holds a valid MD instruction this cycle (0 for bubbles/flushed slots)
- E_MD_A  in  32  rs operand (forwarded E-stage value)
- E_MD_B  in  32  rt operand (forwarded E-stage value)
- D_MD_use  in  1  D-stage instruction is any MD op (1..8)
- E_MD_busy  out  1  multi-cycle operation in progress
- E_MD_HI  out  32  current HI register
- E_MD_LO  out  32  current LO register
- E_MD_out  out  32  mfhi → HI, mflo → LO, else 0 (combinational)
- D_MD_stall  out  1  D_MD_use & (E_MD_busy | (E_MD_start & E_MD_op in 1..4)), combinational

## Operation
- State: HI, LO (32 each), busy flag, cycle counter (≥4 bits), latched result pair (HI_n, LO_n).
- Launch: edge with E_MD_start=1, op in 1..4, busy=0 → compute result from E_MD_A/E_MD_B. The computation is combinational or registered at launch, with free internal structure. Latch the result, load the counter with MULT_CYCLES or DIV_CYCLES, set busy.
- Countdown: each edge while busy decrements the counter. On the edge where counter==1, write HI←HI_n, LO←LO_n and clear busy.
- mult: signed 64-bit product of A×B; HI=[63:32], LO=[31:0]. multu: unsigned.
- div: signed quotient truncated toward zero → LO, remainder (sign of dividend) → HI. divu: unsigned.
- div/divu with B=0: the unit still goes busy for DIV_CYCLES, and HI/LO stay unchanged at completion.
- div with 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo: on an edge with E_MD_start=1 and busy=0, HI←A (mthi) or LO←A (mtlo), with no busy.
- mfhi/mflo: E_MD_out reflects current HI/LO combinationally. No state change.
- E_MD_start with busy=1: ignored, no state change. The stall guarantees this is unreachable in the core.
- E_MD_start=0: op ignored regardless of value.

## Timing
- Reset: HI=0, LO=0, busy=0, counter=0, E_MD_out=0 (op none). A reset at any cycle, including mid-operation, aborts the operation. The pending result is discarded.
- Launch at edge t, for an operation of N cycles:
  - E_MD_busy=1 during cycles t+1 … t+N.
  - HI/LO show the new values from cycle t+N+1, which is also the first cycle with busy=0.
- The same-cycle launch is visible to D via D_MD_stall, in the cycle E_MD_start=1 (before busy rises).
- A new launch is accepted in the first cycle with busy=0. There are no dead cycles between back-to-back operations.
- mthi/mtlo: HI/LO are updated at the accepting edge and visible in the next cycle.
- mfhi reading HI in the cycle after an mthi sees the new value.

## Test plan
- mult A=0xFFFFFFFE, B=3, start 1 cycle:
  - busy high exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - mfhi next cycle → E_MD_out=0xFFFFFFFF.
- multu A=0xFFFFFFFE, B=3 → after 5 busy cycles, HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9 (−7), B=2:
  - busy 10 cycles.
  - Then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu with the same operands → LO=0x7FFFFFFC, HI=0x00000001.
- div by zero after mthi 0x11111111 / mtlo 0x22222222:
  - busy 10 cycles.
  - HI=0x11111111 and LO=0x22222222 are unchanged.
- Stall:
  - Hold D_MD_use=1 and launch mult → D_MD_stall=1 in the launch cycle plus 5 busy cycles, 0 on the first non-busy cycle.
  - With D_MD_use=0, D_MD_stall=0 throughout.
  - A second start issued while busy is ignored.
- Reset mid-operation: launch div, assert reset on the 4th busy cycle → next cycle busy=0, HI=LO=0. No later writeback occurs.

Source files
------------

// File: rtl/e_md_unit.sv
// ---------------------------------------------------------------------------
// e_md_unit -- execute-stage multiply/divide unit.
//
// Runs mult/multu/div/divu as fixed-latency operations against private HI/LO
// registers, handles mthi/mtlo writes and mfhi/mflo reads, and raises the
// decode-stage stall that keeps MD instructions out of E while it is busy.
//
// Ports:
//   clk, reset   : system clock, synchronous active-high reset
//   E_MD_op      : MD opcode (0 none,1 mult,2 multu,3 div,4 divu,
//                  5 mfhi,6 mflo,7 mthi,8 mtlo, others none)
//   E_MD_start   : E stage holds a valid MD instruction
//   E_MD_A/B     : rs/rt operands
//   D_MD_use     : decode-stage instruction is an MD op
//   E_MD_busy    : multi-cycle operation in progress
//   E_MD_HI/LO   : current HI/LO registers
//   E_MD_out     : mfhi/mflo read data (combinational)
//   D_MD_stall   : stall request for the decode stage (combinational)
// ---------------------------------------------------------------------------
module e_md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  E_MD_op,
   input  logic        E_MD_start,
   input  logic [31:0] E_MD_A,
   input  logic [31:0] E_MD_B,
   input  logic        D_MD_use,
   output logic        E_MD_busy,
   output logic [31:0] E_MD_HI,
   output logic [31:0] E_MD_LO,
   output logic [31:0] E_MD_out,
   output logic        D_MD_stall
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = ($clog2(MAXC + 1) > 4) ? $clog2(MAXC + 1) : 4;

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MFHI  = 4'd5,
      OP_MFLO  = 4'd6,
      OP_MTHI  = 4'd7,
      OP_MTLO  = 4'd8
   } md_op_e;

   logic [31:0]   hi_q, lo_q;
   logic [31:0]   hi_n_q, lo_n_q;   // result waiting for writeback
   logic [31:0]   hi_d, lo_d;       // result computed at launch
   logic          busy_q;
   logic [CW-1:0] cnt_q;

   logic [63:0]   prod_s, prod_u;
   logic [31:0]   abs_a, abs_b, div_b, q_mag, r_mag;
   logic [31:0]   q_s, r_s, q_u, r_u;
   logic          is_long_op;

   assign is_long_op = (E_MD_op >= OP_MULT) && (E_MD_op <= OP_DIVU);

   // Signed multiply: both operands signed, so they sign-extend to 64 bits.
   assign prod_s = $signed(E_MD_A) * $signed(E_MD_B);
   assign prod_u = {32'd0, E_MD_A} * {32'd0, E_MD_B};

   // Signed divide on magnitudes; 0x80000000 has magnitude 2^31, which the
   // unsigned path handles, so 0x80000000 / -1 naturally yields 0x80000000.
   assign abs_a = E_MD_A[31] ? (32'd0 - E_MD_A) : E_MD_A;
   assign abs_b = E_MD_B[31] ? (32'd0 - E_MD_B) : E_MD_B;
   // Divide-by-zero result is never used; keep the divider input defined.
   assign div_b = (E_MD_B == 32'd0) ? 32'd1 : E_MD_B;
   assign q_mag = abs_a / ((abs_b == 32'd0) ? 32'd1 : abs_b);
   assign r_mag = abs_a % ((abs_b == 32'd0) ? 32'd1 : abs_b);
   assign q_s   = (E_MD_A[31] ^ E_MD_B[31]) ? (32'd0 - q_mag) : q_mag;
   assign r_s   = E_MD_A[31] ? (32'd0 - r_mag) : r_mag;
   assign q_u   = E_MD_A / div_b;
   assign r_u   = E_MD_A % div_b;

   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      case (E_MD_op)
         OP_MULT:  begin hi_d = prod_s[63:32]; lo_d = prod_s[31:0]; end
         OP_MULTU: begin hi_d = prod_u[63:32]; lo_d = prod_u[31:0]; end
         // Divide by zero re-latches the current HI/LO: writeback is a no-op.
         OP_DIV:   if (E_MD_B != 32'd0) begin hi_d = r_s; lo_d = q_s; end
         OP_DIVU:  if (E_MD_B != 32'd0) begin hi_d = r_u; lo_d = q_u; end
         default:  ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q   <= '0;
         lo_q   <= '0;
         hi_n_q <= '0;
         lo_n_q <= '0;
         busy_q <= 1'b0;
         cnt_q  <= '0;
      end else if (busy_q) begin
         // Starts arriving while busy are dropped; only the countdown runs.
         if (cnt_q == CW'(1)) begin
            hi_q   <= hi_n_q;
            lo_q   <= lo_n_q;
            busy_q <= 1'b0;
            cnt_q  <= '0;
         end else begin
            cnt_q  <= cnt_q - CW'(1);
         end
      end else if (E_MD_start) begin
         case (E_MD_op)
            OP_MULT, OP_MULTU: begin
               hi_n_q <= hi_d;
               lo_n_q <= lo_d;
               cnt_q  <= CW'(MULT_CYCLES);
               busy_q <= 1'b1;
            end
            OP_DIV, OP_DIVU: begin
               hi_n_q <= hi_d;
               lo_n_q <= lo_d;
               cnt_q  <= CW'(DIV_CYCLES);
               busy_q <= 1'b1;
            end
            OP_MTHI: hi_q <= E_MD_A;
            OP_MTLO: lo_q <= E_MD_A;
            default: ;
         endcase
      end
   end

   always_comb begin
      E_MD_out = 32'd0;
      case (E_MD_op)
         OP_MFHI: E_MD_out = hi_q;
         OP_MFLO: E_MD_out = lo_q;
         default: ;
      endcase
   end

   // A launch in E must stall D in the same cycle, before busy rises.
   assign D_MD_stall = D_MD_use & (busy_q | (E_MD_start & is_long_op));
   assign E_MD_busy  = busy_q;
   assign E_MD_HI    = hi_q;
   assign E_MD_LO    = lo_q;

endmodule

// File: tb/tb_e_md_unit.sv
module tb_e_md_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  E_MD_op;
   logic        E_MD_start;
   logic [31:0] E_MD_A, E_MD_B;
   logic        D_MD_use;
   logic        E_MD_busy;
   logic [31:0] E_MD_HI, E_MD_LO, E_MD_out;
   logic        D_MD_stall;

   int checks = 0;
   int errors = 0;

   // Architectural reference state
   logic [31:0] m_hi, m_lo;

   e_md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .E_MD_op(E_MD_op), .E_MD_start(E_MD_start),
      .E_MD_A(E_MD_A), .E_MD_B(E_MD_B), .D_MD_use(D_MD_use),
      .E_MD_busy(E_MD_busy), .E_MD_HI(E_MD_HI), .E_MD_LO(E_MD_LO),
      .E_MD_out(E_MD_out), .D_MD_stall(D_MD_stall)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: MIPS semantics computed with 64-bit arithmetic.
   task automatic model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, p, q, r;
      longint unsigned pu;
      sa = $signed(a);
      sb = $signed(b);
      case (op)
         4'd1: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
         4'd2: begin pu = {32'd0, a} * {32'd0, b}; m_hi = pu[63:32]; m_lo = pu[31:0]; end
         4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; m_hi = r[31:0]; m_lo = q[31:0]; end
         4'd4: if (b != 0) begin m_hi = a % b; m_lo = a / b; end
         4'd7: m_hi = a;
         4'd8: m_lo = a;
         default: ;
      endcase
   endtask

   task automatic check_regs(input string nm);
      checks++;
      if (E_MD_HI !== m_hi) begin
         errors++;
         $display("FAIL %s HI got %h exp %h", nm, E_MD_HI, m_hi);
      end
      checks++;
      if (E_MD_LO !== m_lo) begin
         errors++;
         $display("FAIL %s LO got %h exp %h", nm, E_MD_LO, m_lo);
      end
   endtask

   // Launch a long op, count busy cycles, then check results in the first
   // non-busy cycle. Returns with inputs idle in that cycle.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string nm);
      int n, exp_n;
      exp_n = (op == 4'd1 || op == 4'd2) ? 5 : 10;
      E_MD_op = op; E_MD_A = a; E_MD_B = b; E_MD_start = 1'b1;
      tick();
      E_MD_start = 1'b0; E_MD_op = 4'd0;
      n = 0;
      while (E_MD_busy === 1'b1 && n < 100) begin
         n++;
         tick();
      end
      model_apply(op, a, b);
      checks++;
      if (n != exp_n) begin
         errors++;
         $display("FAIL %s busy_cycles got %0d exp %0d", nm, n, exp_n);
      end
      check_regs(nm);
   endtask

   task automatic mt(input logic [3:0] op, input logic [31:0] a, input string nm);
      E_MD_op = op; E_MD_A = a; E_MD_start = 1'b1;
      tick();
      E_MD_start = 1'b0; E_MD_op = 4'd0;
      model_apply(op, a, 32'd0);
      check_regs(nm);
   endtask

   task automatic mf(input logic [3:0] op, input string nm);
      logic [31:0] exp_v;
      exp_v = (op == 4'd5) ? m_hi : m_lo;
      E_MD_op = op; E_MD_start = 1'b1;
      #1;
      checks++;
      if (E_MD_out !== exp_v) begin
         errors++;
         $display("FAIL %s out got %h exp %h", nm, E_MD_out, exp_v);
      end
      tick();
      E_MD_start = 1'b0; E_MD_op = 4'd0;
      check_regs({nm, "_nochange"});
   endtask

   task automatic test_reset();
      reset = 1'b1; E_MD_op = 4'd0; E_MD_start = 1'b0;
      E_MD_A = '0; E_MD_B = '0; D_MD_use = 1'b0;
      tick(); tick();
      reset = 1'b0;
      m_hi = 0; m_lo = 0;
      check_regs("reset");
      checks++;
      if (E_MD_busy !== 1'b0 || E_MD_out !== 32'd0 || D_MD_stall !== 1'b0) begin
         errors++;
         $display("FAIL reset busy/out/stall got %b/%h/%b exp 0/0/0", E_MD_busy, E_MD_out, D_MD_stall);
      end
   endtask

   task automatic test_no_start();
      // op present without start must do nothing
      E_MD_op = 4'd7; E_MD_A = 32'hDEADBEEF; E_MD_start = 1'b0;
      tick();
      E_MD_op = 4'd1;
      tick();
      E_MD_op = 4'd0;
      checks++;
      if (E_MD_busy !== 1'b0) begin
         errors++;
         $display("FAIL no_start busy got %b exp 0", E_MD_busy);
      end
      check_regs("no_start");
   endtask

   task automatic test_directed();
      run_op(4'd1, 32'hFFFFFFFE, 32'd3, "mult");
      mf(4'd5, "mfhi_after_mult");
      mf(4'd6, "mflo_after_mult");
      run_op(4'd2, 32'hFFFFFFFE, 32'd3, "multu");
      run_op(4'd3, 32'hFFFFFFF9, 32'd2, "div");
      run_op(4'd4, 32'hFFFFFFF9, 32'd2, "divu");
      run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
      mt(4'd7, 32'h11111111, "mthi");
      mf(4'd5, "mfhi_after_mthi");
      mt(4'd8, 32'h22222222, "mtlo");
      run_op(4'd3, 32'h12345678, 32'd0, "div_by_zero");
      run_op(4'd4, 32'h12345678, 32'd0, "divu_by_zero");
   endtask

   task automatic test_stall();
      logic exp_s;
      // D_MD_use held: stall in launch cycle and 5 busy cycles, then drop
      D_MD_use = 1'b1;
      E_MD_op = 4'd1; E_MD_A = $urandom; E_MD_B = $urandom; E_MD_start = 1'b1;
      model_apply(4'd1, E_MD_A, E_MD_B);
      for (int c = 0; c < 7; c++) begin
         #1;
         exp_s = (c < 6);
         checks++;
         if (D_MD_stall !== exp_s) begin
            errors++;
            $display("FAIL stall_use cycle %0d got %b exp %b", c, D_MD_stall, exp_s);
         end
         tick();
         E_MD_start = 1'b0; E_MD_op = 4'd0;
      end
      check_regs("stall_use");
      // D_MD_use low: never stall
      D_MD_use = 1'b0;
      E_MD_op = 4'd3; E_MD_A = $urandom; E_MD_B = $urandom_range(1, 1000); E_MD_start = 1'b1;
      model_apply(4'd3, E_MD_A, E_MD_B);
      for (int c = 0; c < 12; c++) begin
         #1;
         checks++;
         if (D_MD_stall !== 1'b0) begin
            errors++;
            $display("FAIL stall_nouse cycle %0d got %b exp 0", c, D_MD_stall);
         end
         tick();
         E_MD_start = 1'b0; E_MD_op = 4'd0;
      end
      check_regs("stall_nouse");
   endtask

   task automatic test_ignore_busy();
      logic [31:0] a, b;
      int n;
      a = $urandom; b = $urandom;
      E_MD_op = 4'd1; E_MD_A = a; E_MD_B = b; E_MD_start = 1'b1;
      tick();
      // starts presented while busy: mthi then div then mtlo
      E_MD_op = 4'd7; E_MD_A = 32'hA5A5A5A5;
      tick();
      E_MD_op = 4'd3; E_MD_B = 32'd7;
      tick();
      E_MD_op = 4'd8;
      tick();
      E_MD_start = 1'b0; E_MD_op = 4'd0;
      n = 4;
      while (E_MD_busy === 1'b1 && n < 100) begin
         n++;
         tick();
      end
      model_apply(4'd1, a, b);
      checks++;
      if (n != 6) begin
         errors++;
         $display("FAIL ignore_busy cycles_to_idle got %0d exp 6", n);
      end
      check_regs("ignore_busy");
      tick(); tick();
      checks++;
      if (E_MD_busy !== 1'b0) begin
         errors++;
         $display("FAIL ignore_busy relaunch busy got %b exp 0", E_MD_busy);
      end
   endtask

   task automatic test_reset_mid();
      mt(4'd7, 32'hCAFEF00D, "pre_reset_mthi");
      E_MD_op = 4'd3; E_MD_A = 32'd1000; E_MD_B = 32'd7; E_MD_start = 1'b1;
      tick();                      // busy cycle 1
      E_MD_start = 1'b0; E_MD_op = 4'd0;
      tick(); tick(); tick();      // now in busy cycle 4
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_hi = 0; m_lo = 0;
      checks++;
      if (E_MD_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid busy got %b exp 0", E_MD_busy);
      end
      check_regs("reset_mid");
      for (int c = 0; c < 12; c++) tick();
      checks++;
      if (E_MD_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_later busy got %b exp 0", E_MD_busy);
      end
      check_regs("reset_mid_no_writeback");
   endtask

   task automatic test_back_to_back();
      // run_op returns in the first idle cycle and the next launch issues there
      run_op(4'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, "b2b_mult");
      run_op(4'd3, 32'h80000000, 32'd3, "b2b_div");
      run_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, "b2b_multu");
      run_op(4'd4, 32'hFFFFFFFF, 32'd10, "b2b_divu");
   endtask

   task automatic test_random();
      logic [3:0]  op;
      logic [31:0] a, b;
      for (int i = 0; i < 40; i++) begin
         op = 4'($urandom_range(1, 8));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            2: b = 32'($urandom_range(1, 16)) | (b & 32'h80000000);
            default: ;
         endcase
         case (op)
            4'd5, 4'd6: mf(op, "rand_mf");
            4'd7, 4'd8: mt(op, a, "rand_mt");
            default:    run_op(op, a, b, "rand_md");
         endcase
      end
   endtask

   initial begin
      test_reset();
      test_no_start();
      test_directed();
      test_stall();
      test_ignore_busy();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
